// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Two requesters share one 4x4 unsigned multiplier. A three-
//               state FSM (IDLE -> CALC -> RESP) grants one operand pair at a
//               time, spends CALC_CYCLES cycles in CALC, registers the 8-bit
//               product and holds it on the response port until consumed.
//
// Parameters  : CALC_CYCLES  cycles spent in CALC before the product is
//                            captured (legal range 1..4)
//
// Ports       : clk          clock, all state updates on its rising edge
//               rst_n        synchronous active-low reset
//               req0_valid   requester 0 offers an operand pair
//               req0_m/q     requester 0 unsigned operands (4 bits each)
//               req0_ready   requester 0 pair accepted when high with valid
//               req1_*       same set for requester 1
//               rsp_valid    rsp_p / rsp_id are valid
//               rsp_p        unsigned product m*q (8 bits)
//               rsp_id       requester that owns the response
//               rsp_ready    consumer accepts the response when high with valid
//               busy         high whenever the FSM is not in IDLE
//
// Build macro : MULT_ARBITER_FIXED_PRI_EN
//               defined   -> fixed priority, requester 0 wins every tie
//               undefined -> round-robin between the two requesters
//
// Revision    : 1.0  initial release
// ============================================================================
module mult_arbiter #(
    parameter int CALC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    input  logic [3:0] req0_m,
    input  logic [3:0] req0_q,
    output logic       req0_ready,

    input  logic       req1_valid,
    input  logic [3:0] req1_m,
    input  logic [3:0] req1_q,
    output logic       req1_ready,

    output logic       rsp_valid,
    output logic [7:0] rsp_p,
    output logic       rsp_id,
    input  logic       rsp_ready,

    output logic       busy
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CALC = 2'd1;
    localparam logic [1:0] C_RESP = 2'd2;

    // Value loaded into the CALC counter on acceptance. The product is
    // captured on the edge where the counter is already zero, so a load of
    // CALC_CYCLES-1 yields exactly CALC_CYCLES edges from acceptance to
    // rsp_valid.
    localparam logic [1:0] C_CNT_LOAD = 2'(CALC_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_next_state;

    logic [1:0] r_cnt;          // CALC cycles remaining before capture
    logic [3:0] r_m;            // latched operand m of the granted requester
    logic [3:0] r_q;            // latched operand q of the granted requester
    logic       r_id;           // latched owner of the operation in flight
    logic [7:0] r_rsp_p;        // captured product, held until next capture
    logic       r_rsp_id;       // owner of the captured product

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic       w_any_valid;
    logic       w_gnt_id;       // winner when a grant is issued
    logic       w_accept;       // handshake completes on the coming edge
    logic [7:0] w_prod;

    assign w_any_valid = req0_valid | req1_valid;

`ifdef MULT_ARBITER_FIXED_PRI_EN
    // Requester 0 wins whenever it is valid; requester 1 only when alone.
    assign w_gnt_id = ~req0_valid;
`else
    logic r_last_gnt;           // requester granted most recently

    // On a tie the requester not granted last time wins; otherwise the
    // single valid requester wins. With neither valid the value is unused.
    assign w_gnt_id = (req0_valid & req1_valid) ? ~r_last_gnt : req1_valid;

    // The pointer resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_accept) begin
            r_last_gnt <= w_gnt_id;
        end
    end
`endif

    // Readies are gated by rst_n so neither requester sees a grant while
    // reset is asserted, even though the state register is still updating.
    assign w_accept = (r_state == C_IDLE) & w_any_valid & rst_n;

    // The single shared multiplier works only on latched operands, so
    // requesters are free to change their inputs after acceptance.
    assign w_prod = {4'd0, r_m} * {4'd0, r_q};

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_accept) begin
                    w_next_state = C_CALC;
                end
            end
            C_CALC: begin
                if (r_cnt == 2'd0) begin
                    w_next_state = C_RESP;
                end
            end
            C_RESP: begin
                // Readies are low in RESP, so returning to IDLE here means
                // the earliest new acceptance is the following cycle.
                if (rsp_ready) begin
                    w_next_state = C_IDLE;
                end
            end
            default: begin
                w_next_state = C_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        req0_ready = w_accept & ~w_gnt_id;
        req1_ready = w_accept &  w_gnt_id;
        rsp_valid  = (r_state == C_RESP);
        busy       = (r_state != C_IDLE);
    end

    assign rsp_p  = r_rsp_p;
    assign rsp_id = r_rsp_id;

    // ------------------------------------------------------------------------
    // Datapath: operand latch, CALC counter, product capture
    // ------------------------------------------------------------------------
    // Reset clears the latched operands and the captured product, which
    // discards any operation that was in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= 2'd0;
            r_m      <= 4'd0;
            r_q      <= 4'd0;
            r_id     <= 1'b0;
            r_rsp_p  <= 8'd0;
            r_rsp_id <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_accept) begin
                        r_m   <= w_gnt_id ? req1_m : req0_m;
                        r_q   <= w_gnt_id ? req1_q : req0_q;
                        r_id  <= w_gnt_id;
                        r_cnt <= C_CNT_LOAD;
                    end
                end
                C_CALC: begin
                    if (r_cnt == 2'd0) begin
                        r_rsp_p  <= w_prod;
                        r_rsp_id <= r_id;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    // RESP holds everything stable until consumed; rsp_p and
                    // rsp_id keep their values after leaving RESP as well.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter. A predictor decides from
//               the arbitration rules which requester must be granted and
//               queues the expected product, owner and due cycle; a separate
//               monitor pops and compares whenever a response is presented.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int CC = 4;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_m, req0_q, req1_m, req1_q;
    logic       req0_ready, req1_ready;
    logic       rsp_valid;
    logic [7:0] rsp_p;
    logic       rsp_id;
    logic       rsp_ready;
    logic       busy;

    mult_arbiter #(.CALC_CYCLES(CC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_m     (req0_m),
        .req0_q     (req0_q),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_m     (req1_m),
        .req1_q     (req1_q),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_p      (rsp_p),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] p;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp    = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         n_acc    = 0;
    int         n_con    = 0;
    int         last_con = -1;
    bit         m_last   = 1'b1;
    bit         rst_q    = 1'b0;
    bit         head_seen = 1'b0;
    logic [7:0] last_p   = 8'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    // Predictor: while the arbiter is idle, decide the winner from the
    // round-robin (or fixed-priority) rule and queue the expected response.
    always @(negedge clk) begin : p_pred
        bit idle;
        int g;
        if (!rst_n) begin
            chk("ready0_in_reset", {31'd0, req0_ready}, 0);
            chk("ready1_in_reset", {31'd0, req1_ready}, 0);
            n_acc  = 0;
            m_last = 1'b1;
        end else begin
            idle = (n_acc == n_con) && (last_con < cyc);
            if (idle) begin
                g = -1;
                if (req0_valid && req1_valid) begin
`ifdef MULT_ARBITER_FIXED_PRI_EN
                    g = 0;
`else
                    g = m_last ? 0 : 1;
`endif
                end else if (req0_valid) begin
                    g = 0;
                end else if (req1_valid) begin
                    g = 1;
                end
                chk("busy_idle", {31'd0, busy}, 0);
                chk("req0_ready_grant", {31'd0, req0_ready}, (g == 0) ? 1 : 0);
                chk("req1_ready_grant", {31'd0, req1_ready}, (g == 1) ? 1 : 0);
                if (g >= 0) begin
                    exp_t e;
                    e.id  = (g == 1);
                    e.p   = (g == 1) ? 8'(int'(req1_m) * int'(req1_q))
                                     : 8'(int'(req0_m) * int'(req0_q));
                    e.due = cyc + CC + 1;
                    exp_q.push_back(e);
                    n_acc++;
                    m_last = (g == 1);
                end
            end else begin
                chk("busy_active", {31'd0, busy}, 1);
                chk("req0_ready_busy", {31'd0, req0_ready}, 0);
                chk("req1_ready_busy", {31'd0, req1_ready}, 0);
            end
        end
    end

    // Monitor: compares every presented response against the queue head.
    always @(negedge clk) begin : p_mon
        if (!rst_n) begin
            if (!rst_q) begin
                chk("rsp_valid_reset", {31'd0, rsp_valid}, 0);
                chk("busy_reset", {31'd0, busy}, 0);
                chk("rsp_p_reset", {24'd0, rsp_p}, 0);
                chk("rsp_id_reset", {31'd0, rsp_id}, 0);
            end
            exp_q.delete();
            n_con     = 0;
            last_p    = 8'd0;
            head_seen = 1'b0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", {31'd0, rsp_valid}, 0);
            end else begin
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0].id});
                chk("rsp_p", {24'd0, rsp_p}, {24'd0, exp_q[0].p});
                if (!head_seen) begin
                    chk("rsp_latency_cycle", cyc, exp_q[0].due);
                    head_seen = 1'b1;
                end
                if (rsp_ready) begin
                    last_p    = exp_q[0].p;
                    void'(exp_q.pop_front());
                    n_con++;
                    last_con  = cyc;
                    head_seen = 1'b0;
                end
            end
        end else begin
            chk("rsp_p_hold", {24'd0, rsp_p}, {24'd0, last_p});
            if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                chk("rsp_valid_due", {31'd0, rsp_valid}, 1);
                void'(exp_q.pop_front());
                n_con++;
                last_con  = cyc;
                head_seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit id, input logic [3:0] m, input logic [3:0] q);
        if (id) begin
            req1_valid = 1'b1; req1_m = m; req1_q = q;
        end else begin
            req0_valid = 1'b1; req0_m = m; req0_q = q;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            if (i == 59) chk("accept_timeout", 0, 1);
        end
        tick();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_m = 4'd0; req0_q = 4'd0;
        req1_valid = 1'b0; req1_m = 4'd0; req1_q = 4'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single request, largest operands.
        rsp_ready = 1'b1;
        send(1'b0, 4'd15, 4'd15);
        idle_wait(CC + 3);

        // Both requesters valid continuously: strict alternation.
        req0_valid = 1'b1; req0_m = 4'd3; req0_q = 4'd5;
        req1_valid = 1'b1; req1_m = 4'd7; req1_q = 4'd2;
        repeat (5 * (CC + 3)) tick();
        idle_wait(CC + 3);

        // Back-pressure: response held for 5 cycles, then resume.
        rsp_ready = 1'b0;
        send(1'b0, 4'd9, 4'd6);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        tick();
        repeat (5) tick();
        rsp_ready = 1'b1;
        send(1'b1, 4'd4, 4'd0);
        idle_wait(CC + 3);

        // Operands changing during CALC must not affect the result.
        send(1'b1, 4'd10, 4'd12);
        repeat (CC) begin
            req1_m = 4'($urandom); req1_q = 4'($urandom);
            req0_m = 4'($urandom); req0_q = 4'($urandom);
            tick();
        end
        idle_wait(CC + 3);

        // Reset during CALC aborts the operation; next tie goes to 0.
        send(1'b1, 4'd5, 4'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_m = 4'd2; req0_q = 4'd3;
        req1_valid = 1'b1; req1_m = 4'd6; req1_q = 4'd6;
        tick();
        idle_wait(2 * (CC + 3));

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 800; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_m = 4'($urandom); req0_q = 4'($urandom);
            req1_m = 4'($urandom); req1_q = 4'($urandom);
            if (i % 97 == 13) begin
                req0_m = 4'd15; req0_q = 4'd15; req1_m = 4'd0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle_wait(CC + 6);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter CALC_CYCLES, default 1, legal range 1..4: number of cycles the FSM spends in CALC before the product is captured.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_m, req0_q  input  4 each  requester 0 unsigned operands.
REQ-006 req0_ready  output  1  requester 0 operands accepted on this edge when high with req0_valid.
REQ-007 req1_valid, req1_m, req1_q, req1_ready  same as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  rsp_p and rsp_id are valid.
REQ-009 rsp_p  output  8  unsigned product m*q.
REQ-010 rsp_id  output  1  requester that owns the current response (0 or 1).
REQ-011 rsp_ready  input  1  consumer accepts the response on this edge when high with rsp_valid.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Block SHALL contain exactly one 4x4 unsigned multiplier datapath, shared by both requesters through a 3-state FSM: IDLE, CALC, RESP.
REQ-014 IDLE: grant computed combinationally from current req*_valid; only the granted requester sees its req*_ready high; the other ready SHALL be low.
REQ-015 Round-robin: both valid -> grant the requester not granted most recently; one valid -> grant it; neither -> no ready, stay IDLE.
REQ-016 Acceptance edge (valid & ready): latch granted m, q and id, update last-grant pointer, go to CALC, load cycle counter with CALC_CYCLES-1.
REQ-017 CALC: both req*_ready low; counter decrements each cycle; when zero, register product of latched operands into rsp_p, go to RESP.
REQ-018 Latency: rsp_valid SHALL go high exactly CALC_CYCLES+1 edges after the acceptance edge's preceding cycle, i.e. CALC_CYCLES edges after the acceptance edge.
REQ-019 RESP: rsp_valid high; rsp_p and rsp_id held stable until rsp_ready high; then go to IDLE on that edge.
REQ-020 No new request SHALL be accepted in the same cycle the response is consumed; earliest next acceptance is the following cycle.
REQ-021 Product SHALL be full 8-bit, no truncation; 15*15 = 0xE1, x*0 = 0x00.
REQ-022 Operand changes on req*_m/q after acceptance SHALL NOT affect rsp_p.
REQ-023 rsp_p SHALL retain its last value after leaving RESP until the next capture.

Reset
REQ-024 On rising edge with rst_n low: state IDLE, rsp_valid 0, rsp_p 0x00, rsp_id 0, busy 0, counter 0, last-grant pointer = 1 (so requester 0 wins the first tie).
REQ-025 During reset req0_ready and req1_ready SHALL be low.
REQ-026 Reset asserted in CALC or RESP SHALL abort the operation; in-flight result discarded, no rsp_valid pulse after reset release.

Configuration
REQ-027 Macro MULT_ARBITER_FIXED_PRI_EN: defined -> fixed priority, requester 0 always wins when both valid, pointer unused; undefined -> round-robin per REQ-015.

Verification
REQ-028 req0 m=15 q=15 alone, CALC_CYCLES=1, rsp_ready=1 -> rsp_valid 1 edge after acceptance, rsp_p=0xE1, rsp_id=0, back to IDLE.
REQ-029 Both valid continuously, m=3 q=5 (req0), m=7 q=2 (req1), round-robin -> responses ordered id 0 (0x0F), 1 (0x0E), 0, 1.
REQ-030 rsp_ready held low 5 cycles in RESP with m=9 q=6 -> rsp_valid, rsp_p=0x36 stable all 5 cycles; both req*_ready low; accept resumes cycle after release.
REQ-031 CALC_CYCLES=4, req1 m=10 q=12 -> rsp_valid exactly 4 edges after acceptance, rsp_p=0x78, rsp_id=1; operands changed during CALC have no effect.
REQ-032 rst_n low for 1 cycle during CALC -> rsp_valid stays 0, rsp_p=0x00, busy 0; next tie granted to requester 0.
REQ-033 MULT_ARBITER_FIXED_PRI_EN defined, both valid continuously -> every response rsp_id=0; req1 served only when req0_valid low.
